flags_stack: RTL

- Next-generation RAT flag register.
- Holds the live C and Z flags with the same set/clear/load controls as the current flag block.
- Adds a parametrised shadow stack: on each interrupt entry the control unit pushes the live flags, and on RETI it pops them back. This supports nested interrupts up to DEPTH levels.
- Sits between the ALU outputs (C, Z) and the control unit / branch logic; driven by the control unit's decode.

---
 rtl/flags_stack.sv | 99 +++++++++
 1 files changed

// File: rtl/flags_stack.sv
// Live C/Z flag register with a LIFO shadow stack that saves flags on interrupt
// entry and restores them on RETI, with sticky error reporting for misuse.
module flags_stack #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             FLG_C_SET,
  input  logic                             FLG_C_CLR,
  input  logic                             FLG_C_LD,
  input  logic                             C,
  input  logic                             FLG_Z_LD,
  input  logic                             Z,
  input  logic                             FLG_SHAD_PUSH,
  input  logic                             FLG_SHAD_POP,
  input  logic                             ERR_CLR,
  output logic                             C_FLAG,
  output logic                             Z_FLAG,
  output logic [$clog2(DEPTH+1)-1:0]       SHAD_DEPTH,
  output logic                             SHAD_FULL,
  output logic                             SHAD_EMPTY,
  output logic                             SHAD_ERR
);

  localparam int unsigned PTR_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]       stack_q [DEPTH];
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic [PTR_W-1:0] depth_q, depth_d;
  logic             err_q, err_d;

  logic             full_c, empty_c;
  logic             push_ok_c, pop_ok_c, err_ev_c;
  logic [IDX_W-1:0] wr_idx_c, rd_idx_c;

  assign full_c    = (depth_q == PTR_W'(DEPTH));
  assign empty_c   = (depth_q == '0);
  assign push_ok_c = FLG_SHAD_PUSH & ~FLG_SHAD_POP & ~full_c;
  assign pop_ok_c  = FLG_SHAD_POP & ~FLG_SHAD_PUSH & ~empty_c;
  assign err_ev_c  = (FLG_SHAD_PUSH & FLG_SHAD_POP)
                   | (FLG_SHAD_PUSH & full_c)
                   | (FLG_SHAD_POP & empty_c);
  assign wr_idx_c  = IDX_W'(depth_q);
  assign rd_idx_c  = IDX_W'(depth_q - PTR_W'(1));

  // Next-state: a valid pop restores both flags and overrides the flag controls
  always_comb begin
    c_d     = c_q;
    z_d     = z_q;
    depth_d = depth_q;
    err_d   = err_q;

    if (FLG_C_CLR)      c_d = 1'b0;
    else if (FLG_C_SET) c_d = 1'b1;
    else if (FLG_C_LD)  c_d = C;

    if (FLG_Z_LD) z_d = Z;

    if (pop_ok_c) begin
      {c_d, z_d} = stack_q[rd_idx_c];
      depth_d    = depth_q - PTR_W'(1);
    end else if (push_ok_c) begin
      depth_d = depth_q + PTR_W'(1);
    end

    // A new error in the same cycle beats ERR_CLR
    if (err_ev_c)     err_d = 1'b1;
    else if (ERR_CLR) err_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      c_q     <= c_d;
      z_q     <= z_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; entries above the depth counter are don't-care
  always_ff @(posedge CLK) begin
    if (!RST && push_ok_c) stack_q[wr_idx_c] <= {c_q, z_q};
  end

  assign C_FLAG     = c_q;
  assign Z_FLAG     = z_q;
  assign SHAD_DEPTH = depth_q;
  assign SHAD_FULL  = full_c;
  assign SHAD_EMPTY = empty_c;
  assign SHAD_ERR   = err_q;

endmodule
